// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Raster timing generator. Counts pixels/lines under a pixel
//             clock-enable and drives HS/VS, pixel coordinates, a visible-area
//             flag, and per-line / per-frame strobes for the pixel stage.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iclk_en,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oActive,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oLineTick,
  output logic       oFrameTick
);

  localparam int         c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_H_MAX    = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_MAX    = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       c_POL      = 1'(SYNC_POL);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_active;
  logic       w_hs_on;
  logic       w_vs_on;
  logic       w_line_start;
  logic       w_frame_start;

  // Next-count and decode of the current counter position; wrap is by compare.
  always_comb begin
    w_h_last      = (r_h_cnt == c_H_MAX);
    w_v_last      = (r_v_cnt == c_V_MAX);
    w_h_next      = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
    w_v_next      = r_v_cnt;
    if (w_h_last) begin
      w_v_next    = w_v_last ? 10'd0 : r_v_cnt + 10'd1;
    end
    w_active      = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    w_hs_on       = (r_h_cnt >= c_HS_START) && (r_h_cnt <= c_HS_END);
    w_vs_on       = (r_v_cnt >= c_VS_START) && (r_v_cnt <= c_VS_END);
    w_line_start  = (r_h_cnt == 10'd0);
    w_frame_start = w_line_start && (r_v_cnt == c_V_ACT);
  end

  // Pixel/line counters advance once per enabled pixel.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (iclk_en) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  // Outputs register the decode of the pre-edge counters so that sync,
  // active and coordinates stay mutually aligned; ticks last one iclk only.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oVGA_HS    <= ~c_POL;
      oVGA_VS    <= ~c_POL;
      oActive    <= 1'b0;
      oX         <= 10'd0;
      oY         <= 10'd0;
      oLineTick  <= 1'b0;
      oFrameTick <= 1'b0;
    end else begin
      oLineTick  <= iclk_en && w_line_start;
      oFrameTick <= iclk_en && w_frame_start;
      if (iclk_en) begin
        oVGA_HS  <= w_hs_on ? c_POL : ~c_POL;
        oVGA_VS  <= w_vs_on ? c_POL : ~c_POL;
        oActive  <= w_active;
        oX       <= r_h_cnt;
        oY       <= r_v_cnt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen: a default-timing
//             instance and a reduced-size instance (active-high sync) share
//             clock, enable and reset, and are compared every cycle against
//             an arithmetic raster model driven by the enabled-edge count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  // Reduced raster: 15 pixels x 11 lines, sync asserted high.
  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
  localparam int SV_A = 6, SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int S_HT = SH_A + SH_F + SH_S + SH_B;
  localparam int S_VT = SV_A + SV_F + SV_S + SV_B;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic       d_hs, d_vs, d_act, d_lt, d_ft;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_act, s_lt, s_ft;
  logic [9:0] s_x, s_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dflt (
    .iclk(clk), .irst_n(rst_n), .iclk_en(en),
    .oVGA_HS(d_hs), .oVGA_VS(d_vs), .oActive(d_act),
    .oX(d_x), .oY(d_y), .oLineTick(d_lt), .oFrameTick(d_ft)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1)
  ) u_small (
    .iclk(clk), .irst_n(rst_n), .iclk_en(en),
    .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oActive(s_act),
    .oX(s_x), .oY(s_y), .oLineTick(s_lt), .oFrameTick(s_ft)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after k enabled edges since reset: the (k-1)th pixel of
  // a raster walked in row-major order, ticks only if the last edge was enabled.
  function automatic logic [24:0] model(input int k, input logic le,
                                        input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb,
                                        input logic pol);
    int ht, vt, p, x, y;
    logic hsa, vsa, act, lt, ft;
    if (k == 0) return {~pol, ~pol, 1'b0, 10'd0, 10'd0, 2'b00};
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    p   = k - 1;
    x   = p % ht;
    y   = (p / ht) % vt;
    act = (x < ha) && (y < va);
    hsa = (x >= ha + hf) && (x < ha + hf + hs);
    vsa = (y >= va + vf) && (y < va + vf + vs);
    lt  = le && (x == 0);
    ft  = le && (x == 0) && (y == va);
    return {hsa ? pol : ~pol, vsa ? pol : ~pol, act, 10'(x), 10'(y), lt, ft};
  endfunction

  // Model state: enabled edges since reset and whether the last edge was enabled.
  int   k = 0;
  logic last_en = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      last_en = 1'b0;
    end else begin
      last_en = en;
      if (en) k = k + 1;
    end
  end

  // Measurement controls set by the stimulus process.
  logic meas_h = 1'b0;
  logic meas_s = 1'b0;
  int   h_period = 800;
  int   h_low    = 96;

  int   cyc = 0;
  logic prev_d_hs = 1'b1, prev_s_vs = 1'b0;
  logic have_fall = 1'b0, have_ft = 1'b0, have_vs = 1'b0;
  int   last_fall = 0, low_cnt = 0;
  int   lt_cnt = 0, act_cnt = 0, vs_cnt = 0;

  // Per-cycle comparison against the model plus period/width measurements.
  always @(posedge clk) begin
    #1;
    cyc++;
    chk("dflt_outputs", {d_hs, d_vs, d_act, d_x, d_y, d_lt, d_ft},
        model(k, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    chk("small_outputs", {s_hs, s_vs, s_act, s_x, s_y, s_lt, s_ft},
        model(k, last_en, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1));

    if (!meas_h) begin
      have_fall = 1'b0;
    end else begin
      if (prev_d_hs && !d_hs) begin
        chk("hs_fall_x", d_x, 656);
        if (have_fall) chk("hs_period", cyc - last_fall, h_period);
        last_fall = cyc;
        have_fall = 1'b1;
        low_cnt   = 0;
      end
      if (!prev_d_hs && d_hs && have_fall) chk("hs_low_width", low_cnt, h_low);
      if (!d_hs) low_cnt++;
    end
    prev_d_hs = d_hs;

    if (!meas_s) begin
      have_ft = 1'b0;
      have_vs = 1'b0;
    end else begin
      if (s_ft) begin
        if (have_ft) begin
          chk("lines_per_frame", lt_cnt, S_VT);
          chk("active_per_frame", act_cnt, SH_A * SV_A);
        end
        have_ft = 1'b1;
        lt_cnt  = 0;
        act_cnt = 0;
      end
      if (s_lt)  lt_cnt++;
      if (s_act) act_cnt++;
      if (!prev_s_vs && s_vs) begin
        chk("vs_start_x", s_x, 0);
        chk("vs_start_y", s_y, SV_A + SV_F);
        have_vs = 1'b1;
        vs_cnt  = 0;
      end
      if (prev_s_vs && !s_vs && have_vs) chk("vs_width", vs_cnt, SV_S * S_HT);
      if (s_vs) vs_cnt++;
    end
    prev_s_vs = s_vs;
  end

  function automatic int small_x(input int kk);
    return (kk - 1) % S_HT;
  endfunction
  function automatic int small_y(input int kk);
    return ((kk - 1) / S_HT) % S_VT;
  endfunction

  initial begin
    logic found;
    rst_n = 1'b0;
    en    = 1'b0;

    // Reset held while the enable toggles: everything stays at reset values.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = ~en;
      @(posedge clk);
      #2;
      chk("rst_dflt", {d_hs, d_vs, d_act, d_x, d_y, d_lt, d_ft}, {2'b11, 1'b0, 20'd0, 2'b00});
      chk("rst_small", {s_hs, s_vs, s_act, s_x, s_y, s_lt, s_ft}, 25'd0);
    end

    // Release, then first enabled edge.
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #2;
    chk("first_edge_dflt", {d_act, d_x, d_y, d_lt, d_ft}, {1'b1, 20'd0, 2'b10});
    chk("first_edge_small", {s_act, s_x, s_y, s_lt, s_ft}, {1'b1, 20'd0, 2'b10});

    // Constant enable: line timing on the default raster, frame timing on
    // the small raster.
    @(negedge clk);
    h_period = 800;
    h_low    = 96;
    meas_h   = 1'b1;
    meas_s   = 1'b1;
    repeat (3300) @(negedge clk);
    meas_h = 1'b0;
    meas_s = 1'b0;

    // Alternating enable: all periods double.
    h_period = 1600;
    h_low    = 192;
    for (int i = 0; i < 6600; i++) begin
      @(negedge clk);
      en = ~en;
      if (i == 10) meas_h = 1'b1;
    end
    meas_h = 1'b0;

    // Random enable pattern.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
    end

    // Mid-frame reset at a known small-raster position.
    @(negedge clk);
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #2;
      if (k > 0 && small_x(k) == 5 && small_y(k) == 3) found = 1'b1;
    end
    chk("midreset_reached", found, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dflt", {d_hs, d_vs, d_act, d_x, d_y, d_lt, d_ft}, {2'b11, 1'b0, 20'd0, 2'b00});
    chk("async_rst_small", {s_hs, s_vs, s_act, s_x, s_y, s_lt, s_ft}, 25'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("after_rst_small", {s_act, s_x, s_y, s_lt}, {1'b1, 20'd0, 1'b1});
    chk("after_rst_dflt", {d_act, d_x, d_y, d_lt}, {1'b1, 20'd0, 1'b1});

    // Frame wrap on the small raster: last pixel then (0,0).
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (k > 0 && small_x(k) == S_HT - 1 && small_y(k) == S_VT - 1) found = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    chk("wrap_reached", found, 1'b1);
    chk("wrap_last_xy", {s_x, s_y}, {10'(S_HT - 1), 10'(S_VT - 1)});
    @(posedge clk);
    #2;
    chk("wrap_next", {s_x, s_y, s_lt, s_ft}, {20'd0, 2'b10});

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
